// File: rtl/stage_pass_eval_if.sv
// Handshake and ROM bundle for the cascade stage pass evaluator.
// master = evaluator side, slave = pipeline / ROM / collector side.
interface stage_pass_eval_if #(
   parameter int W_DATA = 13,
   parameter int W_ADDR = 12
);
   logic              start;
   logic              busy;
   logic              vote_valid;
   logic              vote_ready;
   logic [W_DATA-1:0] vote_data;
   logic              vote_last;
   logic              rom_en;
   logic [W_ADDR-1:0] rom_addr;
   logic [W_DATA-1:0] rom_data;
   logic              res_valid;
   logic              res_ready;
   logic              res_detect;
   logic [W_ADDR-1:0] res_stage;

   modport master (
      input  start,
      output busy,
      input  vote_valid,
      output vote_ready,
      input  vote_data,
      input  vote_last,
      output rom_en,
      output rom_addr,
      input  rom_data,
      output res_valid,
      input  res_ready,
      output res_detect,
      output res_stage
   );

   modport slave (
      output start,
      input  busy,
      output vote_valid,
      input  vote_ready,
      output vote_data,
      output vote_last,
      input  rom_en,
      input  rom_addr,
      output rom_data,
      input  res_valid,
      output res_ready,
      input  res_detect,
      input  res_stage
   );
endinterface

// File: rtl/stage_pass_eval.sv
// Cascade stage vote accumulator and threshold compare.
// Optional THRESH_PREFETCH_EN: fetch threshold on ACCUM entry.
module stage_pass_eval #(
   parameter int W_DATA   = 13,
   parameter int W_ADDR   = 12,
   parameter int W_ACC    = 18,
   parameter int N_STAGES = 25
) (
   input logic clk,
   input logic rst,
   stage_pass_eval_if.master bus
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ACCUM  = 3'd1;
   localparam logic [2:0] FETCH  = 3'd2;
   localparam logic [2:0] CMP    = 3'd3;
   localparam logic [2:0] RESULT = 3'd4;

   localparam int EXT = W_ACC - W_DATA;

   localparam logic signed [W_ACC-1:0] ACC_MAX =
      {1'b0, {(W_ACC-1){1'b1}}};
   localparam logic signed [W_ACC-1:0] ACC_MIN =
      {1'b1, {(W_ACC-1){1'b0}}};
   localparam logic [W_ADDR-1:0] LAST =
      W_ADDR'(N_STAGES - 1);

   logic [2:0]              state;
   logic [2:0]              state_nx;
   logic signed [W_ACC-1:0] acc;
   logic signed [W_ACC-1:0] acc_sum;
   logic signed [W_ACC-1:0] vote_ext;
   logic signed [W_ACC-1:0] thr_ext;
   logic [W_ACC:0]          sum_wide;
   logic [W_ADDR-1:0]       stage;
   logic                    detect;
   logic                    vote_hs;
   logic                    pass;
   logic                    stage_last;
   logic [W_DATA-1:0]       thr_src;

`ifdef THRESH_PREFETCH_EN
   logic              first;
   logic              thr_load;
   logic [W_DATA-1:0] thr_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         first    <= 1'b0;
         thr_load <= 1'b0;
         thr_reg  <= '0;
      end else begin
         first    <= (state_nx == ACCUM) &&
                     (state != ACCUM);
         thr_load <= bus.rom_en;
         if (thr_load)
            thr_reg <= bus.rom_data;
      end
   end

   assign thr_src    = thr_reg;
   assign bus.vote_ready = (state == ACCUM) & ~first;
   assign bus.rom_en     = (state == ACCUM) & first;
`else
   assign thr_src    = bus.rom_data;
   assign bus.vote_ready = (state == ACCUM);
   assign bus.rom_en     = (state == FETCH);
`endif

   assign vote_hs    = bus.vote_valid & bus.vote_ready;
   assign stage_last = (stage == LAST);

   assign vote_ext =
      {{EXT{bus.vote_data[W_DATA-1]}}, bus.vote_data};
   assign thr_ext  =
      {{EXT{thr_src[W_DATA-1]}}, thr_src};

   // one guard bit exposes overflow for clamping
   assign sum_wide =
      {acc[W_ACC-1], acc} +
      {vote_ext[W_ACC-1], vote_ext};

   always_comb begin
      acc_sum = sum_wide[W_ACC-1:0];
      if (sum_wide[W_ACC] != sum_wide[W_ACC-1])
         acc_sum = sum_wide[W_ACC] ? ACC_MIN : ACC_MAX;
   end

   assign pass = (acc >= thr_ext);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (bus.start)
               state_nx = ACCUM;
         ACCUM:
            if (vote_hs && bus.vote_last)
`ifdef THRESH_PREFETCH_EN
               state_nx = CMP;
`else
               state_nx = FETCH;
`endif
         FETCH:
            state_nx = CMP;
         CMP:
            if (pass && !stage_last)
               state_nx = ACCUM;
            else
               state_nx = RESULT;
         RESULT:
            if (bus.res_ready)
               state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         stage  <= '0;
         detect <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE:
               if (bus.start) begin
                  acc    <= '0;
                  stage  <= '0;
                  detect <= 1'b0;
               end
            ACCUM:
               if (vote_hs)
                  acc <= acc_sum;
            CMP:
               if (pass && !stage_last) begin
                  stage <= stage + W_ADDR'(1);
                  acc   <= '0;
               end else begin
                  detect <= pass;
               end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state != IDLE);
   assign bus.res_valid  = (state == RESULT);
   assign bus.res_detect = (state == RESULT) & detect;
   assign bus.res_stage  = stage;
   assign bus.rom_addr   = stage;

endmodule

// File: tb/tb_stage_pass_eval.sv
// Self-checking bench for stage_pass_eval (two-stage cascade).
module tb_stage_pass_eval;
   localparam int NS = 2;
`ifdef THRESH_PREFETCH_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif
   localparam int AMAX = 131071;
   localparam int AMIN = -131072;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   thr_i [NS];
   logic [12:0] rom_w [NS];
   int   vq [$];
   int   cnt [NS];

   stage_pass_eval_if #(.W_DATA(13), .W_ADDR(12)) vif ();

   stage_pass_eval #(
      .W_DATA(13), .W_ADDR(12),
      .W_ACC(18), .N_STAGES(NS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (vif.rom_en && vif.rom_addr < NS)
         vif.rom_data <= rom_w[vif.rom_addr];

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic int sat(input int x);
      if (x > AMAX) return AMAX;
      if (x < AMIN) return AMIN;
      return x;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_vote(input int v, input bit last);
      int n;
      n = 0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      vif.vote_valid = 1'b1;
      vif.vote_data  = 13'(v);
      vif.vote_last  = last;
      vif.start      = 1'($urandom_range(0, 1));
      while (!vif.vote_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("vote_wait", 32'(n < 40), 1);
      @(negedge clk);
      vif.vote_valid = 1'b0;
      vif.vote_last  = 1'b0;
   endtask

   task automatic run_window(input int hold);
      int  a;
      int  idx;
      int  n;
      int  exp_stage;
      bit  exp_det;
      exp_det   = 1'b1;
      exp_stage = NS - 1;
      idx = 0;
      for (int s = 0; s < NS; s++) begin
         a = 0;
         for (int k = 0; k < cnt[s]; k++) begin
            a = sat(a + vq[idx]);
            idx++;
         end
         if (a < thr_i[s]) begin
            exp_det   = 1'b0;
            exp_stage = s;
            break;
         end
      end
      @(negedge clk);
      vif.start = 1'b1;
      @(negedge clk);
      vif.start = 1'b0;
      chk("busy_start", 32'(vif.busy), 1);
      idx = 0;
      for (int s = 0; s <= exp_stage; s++) begin
         for (int k = 0; k < cnt[s]; k++) begin
            send_vote(vq[idx], k == cnt[s] - 1);
            idx++;
         end
         chk("rom_addr", 32'(vif.rom_addr), s);
         if (s < exp_stage)
            repeat (LAT) @(negedge clk);
      end
      n = 0;
      while (!vif.res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("res_lat", n, LAT);
      vif.start = 1'b1;
      repeat (hold) begin
         chk("hold_valid", 32'(vif.res_valid), 1);
         chk("hold_det", 32'(vif.res_detect), 32'(exp_det));
         chk("hold_stage", 32'(vif.res_stage), exp_stage);
         chk("hold_vready", 32'(vif.vote_ready), 0);
         chk("hold_busy", 32'(vif.busy), 1);
         @(negedge clk);
      end
      chk("res_det", 32'(vif.res_detect), 32'(exp_det));
      chk("res_stage", 32'(vif.res_stage), exp_stage);
      vif.res_ready = 1'b1;
      vif.start     = 1'b0;
      @(negedge clk);
      vif.res_ready = 1'b0;
      chk("res_drop", 32'(vif.res_valid), 0);
      chk("idle_busy", 32'(vif.busy), 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      thr_i[0] = -567;
      thr_i[1] = 339;
      for (int i = 0; i < NS; i++)
         rom_w[i] = thr_i[i][12:0];
      rst            = 1'b1;
      vif.start      = 1'b0;
      vif.vote_valid = 1'b0;
      vif.vote_data  = '0;
      vif.vote_last  = 1'b0;
      vif.res_ready  = 1'b0;
      vif.rom_data   = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(vif.busy), 0);
      chk("rst_vready", 32'(vif.vote_ready), 0);
      chk("rst_rom_en", 32'(vif.rom_en), 0);
      chk("rst_rvalid", 32'(vif.res_valid), 0);
      chk("rst_rdet", 32'(vif.res_detect), 0);
      chk("rst_raddr", 32'(vif.rom_addr), 0);
      chk("rst_rstage", 32'(vif.res_stage), 0);
      rst = 1'b0;

      cnt[0] = 2;
      cnt[1] = 2;
      vq = {-300, -200, 100, 239};
      run_window(5);

      cnt[0] = 1;
      cnt[1] = 1;
      vq = {-600, 0};
      run_window(0);

      cnt[0] = 45;
      cnt[1] = 40;
      vq = {};
      repeat (40) vq.push_back(4095);
      repeat (5)  vq.push_back(-4096);
      repeat (40) vq.push_back(-4096);
      run_window(1);

      cnt[0] = 40;
      cnt[1] = 1;
      vq = {};
      repeat (40) vq.push_back(4095);
      vq.push_back(339);
      run_window(0);

      cnt[0] = 2;
      vq = {100, 50};
      @(negedge clk);
      vif.start = 1'b1;
      @(negedge clk);
      vif.start = 1'b0;
      send_vote(100, 1'b0);
      send_vote(50, 1'b1);
      repeat (LAT - 1) @(negedge clk);
      rst       = 1'b1;
      vif.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(vif.busy), 0);
      chk("abort_rvalid", 32'(vif.res_valid), 0);
      chk("abort_raddr", 32'(vif.rom_addr), 0);
      @(negedge clk);
      chk("abort_rvalid2", 32'(vif.res_valid), 0);
      cnt[0] = 1;
      cnt[1] = 1;
      vq = {-568, 0};
      run_window(2);

      for (int w = 0; w < 40; w++) begin
         vq = {};
         for (int s = 0; s < NS; s++) begin
            cnt[s] = $urandom_range(1, 5);
            for (int k = 0; k < cnt[s]; k++)
               vq.push_back(int'($urandom_range(0, 1400)) - 700);
         end
         run_window($urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
